// File: rtl/io_intr_timer_pkg.sv
// io_intr_timer_pkg
//   Shared definitions for the interrupt timer peripheral: register byte
//   offsets, CTRL/STATUS bit positions, FSM state encodings and the
//   reload-value helper used by both the main counter and the overrun
//   shadow counter.
//   No ports (package).
package io_intr_timer_pkg;

  localparam logic [12:0] IO_CTRL         = 13'h000;
  localparam logic [12:0] IO_RELOAD       = 13'h004;
  localparam logic [12:0] IO_COUNT        = 13'h008;
  localparam logic [12:0] IO_STATUS       = 13'h00C;
  localparam logic [12:0] IO_SCRATCH_BASE = 13'h100;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int STATUS_PEND = 0;
  localparam int STATUS_OVR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_REQ     = 2'd2,
    ST_WAITLOW = 2'd3
  } timer_state_e;

  // A RELOAD of zero would never reach the COUNT==1 event, so it behaves as 1.
  function automatic logic [31:0] eff_reload(input logic [31:0] reload);
    return (reload == 32'd0) ? 32'd1 : reload;
  endfunction

endpackage

// File: rtl/io_intr_timer_if.sv
// io_intr_timer_if
//   CPU io_* bus plus the intr/inta handshake between the CPU and the timer.
//   The tri-stated read bus io_out is shared with dMem and is kept as a plain
//   port on the peripheral rather than living in this interface.
//   Signals:
//     io_cs, io_rd, io_wr  device select and strobes (CPU -> device)
//     io_address, io_d_in  byte address and write data (CPU -> device)
//     inta                 interrupt acknowledge (CPU -> device)
//     intr                 interrupt request (device -> CPU)
//   Modports: master = CPU side, slave = peripheral side.
interface io_intr_timer_if;

  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_address;
  logic [31:0] io_d_in;
  logic        intr;
  logic        inta;

  modport master (
    output io_cs, io_rd, io_wr, io_address, io_d_in, inta,
    input  intr
  );

  modport slave (
    input  io_cs, io_rd, io_wr, io_address, io_d_in, inta,
    output intr
  );

endinterface

// File: rtl/io_intr_timer_scratch.sv
// io_intr_timer_scratch
//   Word-addressed scratch RAM: synchronous write, asynchronous read.
//   Contents are not cleared by reset.
//   Ports:
//     clk    in   system clock
//     we     in   write enable, write lands on posedge clk
//     addr   in   word address shared by read and write
//     wdata  in   write data
//     rdata  out  combinational read data at addr
module io_intr_timer_scratch #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/io_intr_timer.sv
// io_intr_timer
//   Memory-mapped timer that raises a level interrupt request, holds it until
//   the CPU acknowledges with inta, and provides a scratch RAM for ISR data.
//   Ports:
//     clk     in   system clock, all state updates on posedge
//     reset   in   synchronous, active-high
//     bus     io_intr_timer_if.slave: io_cs/io_rd/io_wr/io_address/io_d_in/inta in, intr out
//     io_out  out  read data, driven only while io_cs & io_rd, otherwise high-Z
module io_intr_timer
  import io_intr_timer_pkg::*;
#(
  parameter int          SCRATCH_WORDS = 1024,
  parameter logic [31:0] RELOAD_RST    = 32'd100
) (
  input  logic              clk,
  input  logic              reset,
  io_intr_timer_if.slave    bus,
  output wire  [31:0]       io_out
);

  localparam int          AW              = $clog2(SCRATCH_WORDS);
  localparam logic [31:0] SCRATCH_WORDS_U = SCRATCH_WORDS;

  timer_state_e state_q, state_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  shadow_q, shadow_d;
  logic [31:0]  reload_q, reload_d;
  logic [1:0]   ctrl_q, ctrl_d;
  logic         intr_q, intr_d;
  logic         pend_q, pend_d;
  logic         ovr_q, ovr_d;
  logic         ovr_set;
  logic         en_clear;

  logic         en;
  logic         auto_reload;
  logic [31:0]  rl;

  logic [10:0]  word;
  logic [10:0]  scratch_idx;
  logic         scratch_hit;
  logic         wr;
  logic         sel_ctrl, sel_reload, sel_count, sel_status;
  logic [31:0]  rd_data;
  logic [31:0]  ram_rdata;
  logic         unused_addr_bits;

  assign en          = ctrl_q[CTRL_EN];
  assign auto_reload = ctrl_q[CTRL_AUTO];
  assign rl          = eff_reload(reload_q);

  // Only address bits [12:2] participate in decode.
  assign word             = bus.io_address[12:2];
  assign unused_addr_bits = ^{bus.io_address[31:13], bus.io_address[1:0]};

  assign sel_ctrl    = (word == IO_CTRL[12:2]);
  assign sel_reload  = (word == IO_RELOAD[12:2]);
  assign sel_count   = (word == IO_COUNT[12:2]);
  assign sel_status  = (word == IO_STATUS[12:2]);
  assign scratch_idx = word - IO_SCRATCH_BASE[12:2];
  assign scratch_hit = (word >= IO_SCRATCH_BASE[12:2]) &&
                       ({21'd0, scratch_idx} < SCRATCH_WORDS_U);

  assign wr = bus.io_cs && bus.io_wr;

  io_intr_timer_scratch #(
    .WORDS (SCRATCH_WORDS),
    .AW    (AW)
  ) u_scratch (
    .clk   (clk),
    .we    (wr && scratch_hit),
    .addr  (scratch_idx[AW-1:0]),
    .wdata (bus.io_d_in),
    .rdata (ram_rdata)
  );

  // State register for the timer FSM and all software-visible registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 32'd0;
      shadow_q <= 32'd0;
      reload_q <= RELOAD_RST;
      ctrl_q   <= 2'd0;
      intr_q   <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      intr_q   <= intr_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  // Timer FSM. The EN/AUTO bits it looks at are the registered values, so a
  // CPU write to CTRL in the same cycle as the COUNT==1 event cannot cancel
  // the request. A one-shot (AUTO=0) run clears EN once acknowledged so the
  // timer does not silently re-arm from IDLE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    intr_d   = intr_q;
    pend_d   = pend_q;
    ovr_set  = 1'b0;
    en_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          count_d = rl;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          count_d  = 32'd0;
          pend_d   = 1'b1;
          intr_d   = 1'b1;
          shadow_d = rl;
          state_d  = ST_REQ;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_REQ: begin
        // The shadow counter measures how many auto-reload periods pass while
        // the request is still unacknowledged; each full period is an overrun.
        if (bus.inta) begin
          intr_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_WAITLOW;
        end else if (en && auto_reload) begin
          if (shadow_q <= 32'd1) begin
            ovr_set  = 1'b1;
            shadow_d = rl;
          end else begin
            shadow_d = shadow_q - 32'd1;
          end
        end
      end
      ST_WAITLOW: begin
        if (!bus.inta) begin
          if (en && auto_reload) begin
            count_d = rl;
            state_d = ST_COUNT;
          end else begin
            en_clear = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register writes. A CPU write to CTRL overrides the one-shot EN clear,
  // and a hardware overrun wins over a same-cycle write-1-to-clear of OVR.
  always_comb begin
    ctrl_d   = ctrl_q;
    reload_d = reload_q;
    if (en_clear) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr && sel_ctrl) begin
      ctrl_d = bus.io_d_in[1:0];
    end
    if (wr && sel_reload) begin
      reload_d = bus.io_d_in;
    end
    ovr_d = ovr_set || (ovr_q && !(wr && sel_status && bus.io_d_in[STATUS_OVR]));
  end

  // Combinational read mux; it always reflects pre-edge state, so a
  // simultaneous read and write returns the old value.
  always_comb begin
    rd_data = 32'd0;
    if (sel_ctrl) begin
      rd_data[CTRL_EN]   = ctrl_q[CTRL_EN];
      rd_data[CTRL_AUTO] = ctrl_q[CTRL_AUTO];
    end else if (sel_reload) begin
      rd_data = reload_q;
    end else if (sel_count) begin
      rd_data = count_q;
    end else if (sel_status) begin
      rd_data[STATUS_PEND] = pend_q;
      rd_data[STATUS_OVR]  = ovr_q;
    end else if (scratch_hit) begin
      rd_data = ram_rdata;
    end
  end

  assign io_out   = (bus.io_cs && bus.io_rd) ? rd_data : 32'hz;
  assign bus.intr = intr_q;

endmodule

// File: tb/tb_io_intr_timer.sv
// tb_io_intr_timer
//   Directed bench for io_intr_timer: reset values, timer/interrupt timing,
//   acknowledge handshake, overrun and its clear, scratch RAM and decode.
module tb_io_intr_timer;

  logic        clk;
  logic        reset;
  wire  [31:0] io_out;
  int          tests_run;
  int          tests_failed;
  logic [31:0] rd_val;
  logic        seen_intr;

  io_intr_timer_if bus ();

  io_intr_timer #(
    .SCRATCH_WORDS (1024),
    .RELOAD_RST    (32'd100)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.io_cs      = 1'b1;
    bus.io_wr      = 1'b1;
    bus.io_address = addr;
    bus.io_d_in    = data;
    tick();
    bus.io_cs      = 1'b0;
    bus.io_wr      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.io_cs      = 1'b1;
    bus.io_rd      = 1'b1;
    bus.io_address = addr;
    #1;
    data           = io_out;
    bus.io_cs      = 1'b0;
    bus.io_rd      = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
    logic [31:0] v;
    bus_read(addr, v);
    check_output(tag, v, expected);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    bus.io_cs      = 1'b0;
    bus.io_rd      = 1'b0;
    bus.io_wr      = 1'b0;
    bus.io_address = 32'd0;
    bus.io_d_in    = 32'd0;
    bus.inta       = 1'b0;
    reset          = 1'b1;
    tick();
    reset = 1'b0;

    // Reset values and undriven read bus
    check_output("rst_intr", {31'd0, bus.intr}, 32'd0);
    check_read("rst_reload", 32'h004, 32'd100);
    check_read("rst_count", 32'h008, 32'd0);
    check_read("rst_ctrl", 32'h000, 32'd0);
    check_read("rst_status", 32'h00C, 32'd0);
    bus.io_cs      = 1'b0;
    bus.io_rd      = 1'b1;
    bus.io_address = 32'h004;
    #1;
    check_output("idle_not_driven", {31'd0, (io_out === 32'hz) || (io_out === 32'h0)}, 32'd1);
    bus.io_rd = 1'b0;

    // One-shot period of 5: request 6 edges after the CTRL write
    bus_write(32'h004, 32'd5);
    check_read("reload_wr", 32'h004, 32'd5);
    bus_write(32'h000, 32'd1);
    tick();
    tick();
    check_read("count_running", 32'h008, 32'd4);
    tick();
    tick();
    tick();
    check_output("t2_intr_edge5", {31'd0, bus.intr}, 32'd0);
    tick();
    check_output("t2_intr_edge6", {31'd0, bus.intr}, 32'd1);
    check_read("t2_status", 32'h00C, 32'd1);
    bus_write(32'h008, 32'h55);
    check_read("count_read_only", 32'h008, 32'd0);

    // Long acknowledge, then no further request with AUTO=0
    bus.inta = 1'b1;
    tick();
    check_output("t3_intr_dropped", {31'd0, bus.intr}, 32'd0);
    tick();
    tick();
    bus.inta = 1'b0;
    check_read("t3_status", 32'h00C, 32'd0);
    seen_intr = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.intr) seen_intr = 1'b1;
    end
    check_output("t3_no_second", {31'd0, seen_intr}, 32'd0);

    // Auto-reload with an unacknowledged request -> overrun
    bus_write(32'h004, 32'd4);
    bus_write(32'h000, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    check_output("t4_intr_edge4", {31'd0, bus.intr}, 32'd0);
    tick();
    check_output("t4_intr_edge5", {31'd0, bus.intr}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check_read("t4_status_ovr", 32'h00C, 32'd3);
    bus_write(32'h00C, 32'd2);
    check_read("t4_status_w1c", 32'h00C, 32'd1);
    bus.inta = 1'b1;
    tick();
    check_output("t4_ack", {31'd0, bus.intr}, 32'd0);
    bus.inta = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_output("t4_rearm_edge4", {31'd0, bus.intr}, 32'd0);
    tick();
    check_output("t4_rearm_edge5", {31'd0, bus.intr}, 32'd1);

    // Simultaneous read and write returns the old value
    bus.io_cs      = 1'b1;
    bus.io_rd      = 1'b1;
    bus.io_wr      = 1'b1;
    bus.io_address = 32'h004;
    bus.io_d_in    = 32'd9;
    #1;
    rd_val = io_out;
    check_output("rdwr_old", rd_val, 32'd4);
    tick();
    bus.io_cs = 1'b0;
    bus.io_rd = 1'b0;
    bus.io_wr = 1'b0;
    check_read("rdwr_new", 32'h004, 32'd9);

    // Reset while a request is outstanding
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("t6_intr", {31'd0, bus.intr}, 32'd0);
    check_read("t6_ctrl", 32'h000, 32'd0);
    check_read("t6_reload", 32'h004, 32'd100);
    seen_intr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.intr) seen_intr = 1'b1;
    end
    check_output("t6_no_intr", {31'd0, seen_intr}, 32'd0);

    // Scratch RAM and address decode
    bus_write(32'h100, 32'hDEADBEEF);
    bus_write(32'h104, 32'h12345678);
    check_read("scr_0", 32'h100, 32'hDEADBEEF);
    check_read("scr_1", 32'h104, 32'h12345678);
    check_read("scr_byte_bits", 32'h103, 32'hDEADBEEF);
    check_read("scr_high_bits", 32'h2000_0104, 32'h12345678);
    check_read("scr_past_end", 32'h1100, 32'd0);
    check_read("unmapped", 32'h010, 32'd0);

    // RELOAD of zero behaves as one
    bus_write(32'h004, 32'd0);
    bus_write(32'h000, 32'd1);
    tick();
    check_output("rl0_edge1", {31'd0, bus.intr}, 32'd0);
    tick();
    check_output("rl0_edge2", {31'd0, bus.intr}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
